// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types and constants for the snoop bus arbiter and the MSI cache controllers.
// The cache controllers should import SOURCE_DMEM / SOURCE_OTHER_PROC from here.
package snoop_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        XFER,
        MEM,
        INVAL
    } bus_state_t;

    typedef enum logic [1:0] {
        REQ_R,
        REQ_W,
        REQ_INV
    } req_type_t;

    localparam logic [1:0] SOURCE_DMEM       = 2'b00;
    localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;

    // A single pulse may carry several request bits; write beats read beats invalidate.
    function automatic req_type_t decode_req(input logic rm, input logic wm);
        if (wm)      return REQ_W;
        else if (rm) return REQ_R;
        else         return REQ_INV;
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_bus_rr_picker.sv
// Two-requester round-robin picker: rr_ptr only breaks ties when both CPUs are pending.
module bus_rr_picker
    import snoop_bus_arbiter_pkg::*;
(
    input  logic [1:0] pending,
    input  logic       rr_ptr,
    output logic       owner,
    output logic       valid
);

    always_comb begin
        valid = |pending;
        owner = (pending == 2'b11) ? rr_ptr : pending[1];
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus / unified-memory port arbiter shared by the two MSI data-cache controllers.
// Latches one request per CPU, grants round-robin, snoops the peer, steers fill data, broadcasts invalidates.
module snoop_bus_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        read_miss,
    input  logic [1:0]        write_miss,
    input  logic [1:0]        invalidate,
    input  logic [ADDR_W-1:0] BICO0,
    input  logic [ADDR_W-1:0] BICO1,
    input  logic [1:0]        cpu_search_found,
    input  logic [DATA_W-1:0] send_other_proc_data0,
    input  logic [DATA_W-1:0] send_other_proc_data1,
    input  logic              u_rdy,
    output logic [1:0]        grant,
    output logic [1:0]        cpu_search,
    output logic [1:0]        invalidate_from_other_cpu,
    output logic [ADDR_W-1:0] BOCI,
    output logic [1:0]        cpu_datasel,
    output logic [DATA_W-1:0] other_proc_data,
    output logic              bus_timeout
);

    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

    bus_state_t        state, state_n;
    logic [1:0]        pend;
    req_type_t         ptype [2];
    logic [ADDR_W-1:0] paddr [2];

    logic              owner;
    req_type_t         cur_type;
    logic [ADDR_W-1:0] cur_addr;
    logic              inv_after;
    logic              rr_ptr;
    logic [6:0]        cnt;

    logic              pick_owner, pick_valid;
    logic              peer;
    logic              done;
    logic              set_inv_after;

    bus_rr_picker u_picker (
        .pending (pend),
        .rr_ptr  (rr_ptr),
        .owner   (pick_owner),
        .valid   (pick_valid)
    );

    assign peer = ~owner;

    always_comb begin
        state_n                   = state;
        grant                     = '0;
        cpu_search                = '0;
        invalidate_from_other_cpu = '0;
        BOCI                      = '0;
        cpu_datasel               = SOURCE_DMEM;
        other_proc_data           = '0;
        bus_timeout               = 1'b0;
        done                      = 1'b0;
        set_inv_after             = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid)
                    state_n = (ptype[pick_owner] == REQ_INV) ? INVAL : SNOOP;
            end
            SNOOP: begin
                cpu_search[peer] = 1'b1;
                BOCI             = cur_addr;
                state_n          = (cpu_search_found[peer] && cur_type == REQ_R) ? XFER : MEM;
                set_inv_after    = cpu_search_found[peer] && cur_type == REQ_W;
            end
            XFER: begin
                grant[owner]    = 1'b1;
                cpu_datasel     = SOURCE_OTHER_PROC;
                other_proc_data = peer ? send_other_proc_data1 : send_other_proc_data0;
                state_n         = IDLE;
                done            = 1'b1;
            end
            MEM: begin
                grant[owner] = 1'b1;
                BOCI         = cur_addr;
                if (u_rdy) begin
                    if (inv_after || cur_type == REQ_W) begin
                        state_n = INVAL;
                    end else begin
                        state_n = IDLE;
                        done    = 1'b1;
                    end
                end else if (cnt == CNT_LAST) begin
                    bus_timeout = 1'b1;
                    state_n     = IDLE;
                    done        = 1'b1;
                end
            end
            INVAL: begin
                invalidate_from_other_cpu[peer] = 1'b1;
                BOCI                            = cur_addr;
                grant[owner]                    = 1'b1;
                state_n                         = IDLE;
                done                            = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                ptype[i] <= REQ_R;
                paddr[i] <= '0;
            end
            owner     <= 1'b0;
            cur_type  <= REQ_R;
            cur_addr  <= '0;
            inv_after <= 1'b0;
            rr_ptr    <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_n;
            // A pulse on the cycle the owner's entry clears still sees it full and is dropped.
            for (int unsigned i = 0; i < 2; i++) begin
                if (done && owner == 1'(i)) begin
                    pend[i] <= 1'b0;
                end else if (!pend[i] && (read_miss[i] || write_miss[i] || invalidate[i])) begin
                    pend[i]  <= 1'b1;
                    ptype[i] <= decode_req(read_miss[i], write_miss[i]);
                    paddr[i] <= (i == 0) ? BICO0 : BICO1;
                end
            end
            if (state == IDLE && pick_valid) begin
                owner     <= pick_owner;
                cur_type  <= ptype[pick_owner];
                cur_addr  <= paddr[pick_owner];
                rr_ptr    <= ~pick_owner;
                inv_after <= 1'b0;
            end else if (set_inv_after) begin
                inv_after <= 1'b1;
            end
            cnt <= (state == MEM) ? cnt + 7'd1 : '0;
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the arbiter.
module tb_snoop_bus_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  read_miss, write_miss, invalidate, cpu_search_found;
    logic [12:0] BICO0, BICO1;
    logic [15:0] w0, w1;
    logic        u_rdy;
    logic [1:0]  grant, cpu_search, inv_other, cpu_datasel;
    logic [12:0] BOCI;
    logic [15:0] other_proc_data;
    logic        bus_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    snoop_bus_arbiter #(.ADDR_W(13), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .read_miss                 (read_miss),
        .write_miss                (write_miss),
        .invalidate                (invalidate),
        .BICO0                     (BICO0),
        .BICO1                     (BICO1),
        .cpu_search_found          (cpu_search_found),
        .send_other_proc_data0     (w0),
        .send_other_proc_data1     (w1),
        .u_rdy                     (u_rdy),
        .grant                     (grant),
        .cpu_search                (cpu_search),
        .invalidate_from_other_cpu (inv_other),
        .BOCI                      (BOCI),
        .cpu_datasel               (cpu_datasel),
        .other_proc_data           (other_proc_data),
        .bus_timeout               (bus_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: per-CPU request slots plus one active transaction
    // described by its kind and how far through its bus phases it has progressed.
    bit mp [2];
    int mty [2];              // 0 read, 1 write, 2 invalidate
    int mad [2];
    bit mrr;
    bit busy;
    int own, tty, tad, step, memc;
    bit iaft;                 // step: 1 snoop, 2 peer transfer, 3 memory wait, 4 invalidate broadcast

    always @(negedge clk) begin
        logic [1:0]  e_grant, e_search, e_inv, e_dsel;
        logic [12:0] e_boci;
        logic [15:0] e_data;
        logic        e_to;
        bit          fin;
        bit          lat [2];
        e_grant = '0; e_search = '0; e_inv = '0; e_dsel = '0;
        e_boci = '0; e_data = '0; e_to = 1'b0;
        if (busy) begin
            if (step == 1) begin
                e_search[1-own] = 1'b1; e_boci = 13'(tad);
            end else if (step == 2) begin
                e_grant[own] = 1'b1; e_dsel = 2'b01; e_data = (own == 0) ? w1 : w0;
            end else if (step == 3) begin
                e_grant[own] = 1'b1; e_boci = 13'(tad);
                e_to = !u_rdy && memc == TIMEOUT - 1;
            end else begin
                e_inv[1-own] = 1'b1; e_grant[own] = 1'b1; e_boci = 13'(tad);
            end
        end
        if (chk_en) begin
            chk("grant", 32'(grant), 32'(e_grant));
            chk("cpu_search", 32'(cpu_search), 32'(e_search));
            chk("inval_other", 32'(inv_other), 32'(e_inv));
            chk("BOCI", 32'(BOCI), 32'(e_boci));
            chk("datasel", 32'(cpu_datasel), 32'(e_dsel));
            chk("other_data", 32'(other_proc_data), 32'(e_data));
            chk("bus_timeout", 32'(bus_timeout), 32'(e_to));
        end
        if (!rst_n) begin
            mp[0] = 0; mp[1] = 0; mrr = 0; busy = 0; step = 0; memc = 0; iaft = 0;
        end else begin
            for (int i = 0; i < 2; i++)
                lat[i] = !mp[i] && (read_miss[i] || write_miss[i] || invalidate[i]);
            fin = 0;
            if (!busy) begin
                if (mp[0] || mp[1]) begin
                    own  = (mp[0] && mp[1]) ? int'(mrr) : (mp[1] ? 1 : 0);
                    mrr  = (own == 0);
                    tty  = mty[own]; tad = mad[own];
                    busy = 1; iaft = 0; memc = 0;
                    step = (tty == 2) ? 4 : 1;
                end
            end else if (step == 1) begin
                if (cpu_search_found[1-own] && tty == 0) step = 2;
                else begin step = 3; memc = 0; end
                if (cpu_search_found[1-own] && tty == 1) iaft = 1;
            end else if (step == 3) begin
                if (u_rdy) begin
                    if (tty == 1 || iaft) step = 4; else fin = 1;
                end else if (memc == TIMEOUT - 1) fin = 1;
                else memc++;
            end else begin
                fin = 1;
            end
            if (fin) begin busy = 0; mp[own] = 0; end
            for (int i = 0; i < 2; i++)
                if (lat[i]) begin
                    mp[i]  = 1;
                    mty[i] = write_miss[i] ? 1 : (read_miss[i] ? 0 : 2);
                    mad[i] = (i == 0) ? int'(BICO0) : int'(BICO1);
                end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; read_miss = '0; write_miss = '0; invalidate = '0;
        cpu_search_found = '0; BICO0 = '0; BICO1 = '0; w0 = '0; w1 = '0; u_rdy = 1'b0;
        tick; chk_en = 1; tick;
        #2 chk("rst grant", 32'(grant), 0); chk("rst BOCI", 32'(BOCI), 0);
        chk("rst search", 32'(cpu_search), 0);
        rst_n = 1'b1; tick;

        // CPU0 read miss, no peer hit, memory ready in fourth MEM cycle
        read_miss = 2'b01; BICO0 = 13'h0104;
        tick; read_miss = '0;
        tick; #2 chk("t1 search", 32'(cpu_search), 32'b10); chk("t1 snoop BOCI", 32'(BOCI), 32'h0104);
        tick; #2 chk("t1 mem grant", 32'(grant), 32'b01); chk("t1 datasel", 32'(cpu_datasel), 0);
        chk("t1 mem BOCI", 32'(BOCI), 32'h0104);
        tick; tick;
        tick; u_rdy = 1'b1; #2 chk("t1 rdy grant", 32'(grant), 32'b01);
        tick; u_rdy = 1'b0; #2 chk("t1 idle grant", 32'(grant), 0);

        // CPU1 read miss, CPU0 holds the line
        read_miss = 2'b10; BICO1 = 13'h0200; cpu_search_found = 2'b01; w0 = 16'hBEEF;
        tick; read_miss = '0;
        tick; #2 chk("t2 search", 32'(cpu_search), 32'b01); chk("t2 BOCI", 32'(BOCI), 32'h0200);
        tick; #2 chk("t2 grant", 32'(grant), 32'b10); chk("t2 datasel", 32'(cpu_datasel), 32'b01);
        chk("t2 data", 32'(other_proc_data), 32'hBEEF);
        tick; #2 chk("t2 idle grant", 32'(grant), 0);

        // Simultaneous read misses with the pointer at CPU0
        read_miss = 2'b11; cpu_search_found = 2'b11;
        tick; read_miss = '0;
        tick; #2 chk("t3 search a", 32'(cpu_search), 32'b10);
        tick; #2 chk("t3 grant a", 32'(grant), 32'b01);
        tick;
        tick; #2 chk("t3 search b", 32'(cpu_search), 32'b01);
        tick; #2 chk("t3 grant b", 32'(grant), 32'b10);
        tick; cpu_search_found = '0;

        // CPU0 upgrade invalidate skips the snoop
        invalidate = 2'b01; BICO0 = 13'h0033;
        tick; invalidate = '0;
        tick; #2 chk("t4 inval", 32'(inv_other), 32'b10); chk("t4 BOCI", 32'(BOCI), 32'h0033);
        chk("t4 grant", 32'(grant), 32'b01); chk("t4 search", 32'(cpu_search), 0);
        tick; #2 chk("t4 after", 32'(inv_other), 0);

        // Simultaneous read misses with the pointer now at CPU1
        read_miss = 2'b11; cpu_search_found = 2'b11;
        tick; read_miss = '0;
        tick; #2 chk("t3b search a", 32'(cpu_search), 32'b01);
        tick; #2 chk("t3b grant a", 32'(grant), 32'b10);
        tick;
        tick; #2 chk("t3b search b", 32'(cpu_search), 32'b10);
        tick; #2 chk("t3b grant b", 32'(grant), 32'b01);
        tick; cpu_search_found = '0;

        // CPU1 write miss, memory never ready
        write_miss = 2'b10; BICO1 = 13'h0040;
        tick; write_miss = '0;
        tick; tick;
        for (int k = 0; k < TIMEOUT; k++) begin
            #2 chk("t5 timeout", 32'(bus_timeout), 32'(k == TIMEOUT - 1));
            chk("t5 grant", 32'(grant), 32'b10);
            tick;
        end
        #2 chk("t5 idle grant", 32'(grant), 0); chk("t5 idle timeout", 32'(bus_timeout), 0);

        // Reset while in MEM
        read_miss = 2'b01; BICO0 = 13'h0111;
        tick; read_miss = '0;
        tick; tick; #2 chk("t6 mem grant", 32'(grant), 32'b01);
        tick; rst_n = 1'b0;
        tick; #2 chk("t6 rst grant", 32'(grant), 0); chk("t6 rst BOCI", 32'(BOCI), 0);
        rst_n = 1'b1;
        tick; tick; tick;
        #2 chk("t6 no rearb grant", 32'(grant), 0); chk("t6 no rearb search", 32'(cpu_search), 0);

        // Randomized traffic
        for (int c = 0; c < 5000; c++) begin
            tick;
            rst_n = ($urandom_range(0, 599) != 0);
            for (int i = 0; i < 2; i++) begin
                read_miss[i]  = ($urandom_range(0, 9) == 0);
                write_miss[i] = ($urandom_range(0, 11) == 0);
                invalidate[i] = ($urandom_range(0, 13) == 0);
            end
            BICO0 = 13'($urandom); BICO1 = 13'($urandom);
            cpu_search_found = 2'($urandom);
            w0 = 16'($urandom); w1 = 16'($urandom);
            u_rdy = (c >= 2500 && c < 3300) ? 1'b0 : ($urandom_range(0, 3) == 0);
        end
        tick;
        rst_n = 1'b1; read_miss = '0; write_miss = '0; invalidate = '0; u_rdy = 1'b1;
        repeat (10) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
